// File: rtl/sntc_ldpc_pkg.sv
// Shared types and helpers for the LDPC encoder sequencer.
// Holds the FSM state encoding, default code sizes and a saturating increment.
package sntc_ldpc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam int MM_DEF = 'h000a8;
    localparam int NN_DEF = 'h000d0;

    // Increments v, but never past max.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] max
    );
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/sntc_sat_counter.sv
// Saturating statistics counter with synchronous clear.
// Ports: clk, rstn, inc (count one event), clr (zero next cycle), cnt (value).
module sntc_sat_counter
    import sntc_ldpc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_V = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = W'(sat_inc(32'(cnt_q), 32'(MAX_V)));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sntc_ldpc_encoder_ctrl.sv
// Sequencer for the LDPC encoder + syndrome checker: one word in flight.
// Ports: in_* accept handshake, enc_* encoder/checker side, out_* result
// handshake, busy, and saturating pass/fail counters cnt_ok/cnt_err.
module sntc_ldpc_encoder_ctrl
    import sntc_ldpc_pkg::*;
#(
    parameter int MM      = MM_DEF,
    parameter int NN      = NN_DEF,
    parameter int K       = NN - MM,
    parameter int CHK_LAT = 2,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_data,
    output logic [K-1:0]     enc_y_nr_in_port,
    output logic             enc_clr,
    input  logic [NN-1:0]    enc_y_nr,
    input  logic             enc_valid_cword,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NN-1:0]    out_cword,
    output logic             out_err,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] LAT_V = WAIT_W'(CHK_LAT);
    localparam logic [WAIT_W-1:0] TO_V  = WAIT_W'(TIMEOUT - 1);

    state_e state_q, state_d;
    logic [K-1:0]      data_q, data_d;
    logic [NN-1:0]     cword_q, cword_d;
    logic              err_q, err_d;
    logic              enc_clr_q, enc_clr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              pass, fail;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pass    = 1'b0;
        fail    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // Early valid_cword may still describe the previous word.
                if (enc_valid_cword && (wait_q >= LAT_V)) begin
                    pass    = 1'b1;
                    state_d = ST_DONE;
                end else if (wait_q == TO_V) begin
                    fail    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr) begin
            state_d = ST_IDLE;
            pass    = 1'b0;
            fail    = 1'b0;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
    end

    always_comb begin
        data_d    = data_q;
        cword_d   = cword_q;
        err_d     = err_q;
        wait_d    = wait_q;
        if ((state_q == ST_IDLE) && in_valid) data_d = in_data;
        if (state_q == ST_START) wait_d = '0;
        if (state_q == ST_CHECK) wait_d = wait_q + 1'b1;
        if (pass || fail) begin
            cword_d = enc_y_nr;
            err_d   = fail;
        end
        // Registered decode so the clear pulse covers exactly START.
        enc_clr_d = (state_d == ST_START);
        if (clr) begin
            data_d    = '0;
            cword_d   = '0;
            err_d     = 1'b0;
            wait_d    = '0;
            enc_clr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q    <= '0;
            cword_q   <= '0;
            err_q     <= 1'b0;
            wait_q    <= '0;
            enc_clr_q <= 1'b1;
        end else begin
            data_q    <= data_d;
            cword_q   <= cword_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
            enc_clr_q <= enc_clr_d;
        end
    end

    assign enc_y_nr_in_port = data_q;
    assign out_cword        = cword_q;
    assign out_err          = err_q;
    assign enc_clr          = enc_clr_q;

    sntc_sat_counter #(.W(CNT_W)) u_cnt_ok (
        .clk  (clk),
        .rstn (rstn),
        .inc  (pass),
        .clr  (clr),
        .cnt  (cnt_ok)
    );

    sntc_sat_counter #(.W(CNT_W)) u_cnt_err (
        .clk  (clk),
        .rstn (rstn),
        .inc  (fail),
        .clr  (clr),
        .cnt  (cnt_err)
    );

endmodule

// File: tb/tb_sntc_ldpc_encoder_ctrl.sv
// Directed bench for the LDPC encoder sequencer.
// Models encoder and syndrome checker; results go through a scoreboard queue.
module tb_sntc_ldpc_encoder_ctrl;

    localparam int MM = 168;
    localparam int NN = 208;
    localparam int K  = NN - MM;

    typedef struct {
        logic [NN-1:0] cword;
        logic          err;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [K-1:0]  in_data = '0;
    logic [K-1:0]  enc_y_nr_in_port;
    logic          enc_clr;
    logic [NN-1:0] enc_y_nr;
    logic          enc_valid_cword;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [NN-1:0] out_cword;
    logic          out_err;
    logic          busy;
    logic [15:0]   cnt_ok;
    logic [15:0]   cnt_err;

    int   checks = 0;
    int   failures = 0;
    int   vc_mode = 0;
    int   since = 0;
    exp_t sb[$];
    logic [15:0] exp_ok = '0;
    logic [15:0] exp_err = '0;

    always #5 clk = ~clk;

    function automatic logic [NN-1:0] enc_model(input logic [K-1:0] d);
        return {d[19:0], d[39:20], d, d[9:0], d[39:10],
                d ^ {d[0], d[39:1]}, d[7:0], d};
    endfunction

    // Checker model: cycles since the encoder clear pulse ended.
    always @(posedge clk) since <= enc_clr ? 0 : since + 1;

    assign enc_y_nr = enc_model(enc_y_nr_in_port);
    assign enc_valid_cword = (vc_mode == 1 && since >= 2) ||
                             (vc_mode == 2 && since == 1);

    sntc_ldpc_encoder_ctrl dut (
        .clk              (clk),
        .rstn             (rstn),
        .clr              (clr),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .enc_y_nr_in_port (enc_y_nr_in_port),
        .enc_clr          (enc_clr),
        .enc_y_nr         (enc_y_nr),
        .enc_valid_cword  (enc_valid_cword),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_cword        (out_cword),
        .out_err          (out_err),
        .busy             (busy),
        .cnt_ok           (cnt_ok),
        .cnt_err          (cnt_err)
    );

    task automatic chk(input string tag, input logic [NN-1:0] obs,
                       input logic [NN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_accept(input logic [K-1:0] d, input bit err,
                             input int lat);
        exp_t e;
        @(negedge clk);
        chk("accept_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_enc_clr", enc_clr, 1'b1);
        chk("held_data", enc_y_nr_in_port, d);
        e.cword = enc_model(d);
        e.err   = err;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    task automatic wait_result(output bit ok);
        int   lat;
        exp_t e;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("out_valid_seen", ok, 1'b1);
        if (ok && sb.size() > 0) begin
            e = sb.pop_front();
            chk("latency", lat, e.lat);
            chk("out_cword", out_cword, e.cword);
            chk("out_err", out_err, e.err);
            chk("done_in_ready", in_ready, 1'b0);
            if (e.err) begin
                exp_err = (exp_err == 16'hFFFF) ? exp_err : exp_err + 1'b1;
            end else begin
                exp_ok = (exp_ok == 16'hFFFF) ? exp_ok : exp_ok + 1'b1;
            end
            chk("cnt_ok", cnt_ok, exp_ok);
            chk("cnt_err", cnt_err, exp_err);
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("hs_out_valid", out_valid, 1'b0);
        chk("hs_in_ready", in_ready, 1'b1);
    endtask

    task automatic run_word(input logic [K-1:0] d, input int mode,
                            input bit err, input int lat);
        bit ok;
        vc_mode = mode;
        do_accept(d, err, lat);
        wait_result(ok);
        if (ok) handshake();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [K-1:0]  d4;
        logic [NN-1:0] held;

        // Reset values while reset is asserted.
        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_err", out_err, 1'b0);
        chk("rst_out_cword", out_cword, '0);
        chk("rst_port", enc_y_nr_in_port, '0);
        chk("rst_enc_clr", enc_clr, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt_ok", cnt_ok, 16'd0);
        chk("rst_cnt_err", cnt_err, 16'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_enc_clr", enc_clr, 1'b0);

        // Pass at the earliest trusted cycle.
        run_word('0, 1, 1'b0, 4);

        // Checker never confirms: timeout.
        run_word(40'h5A5A5A5A5A, 0, 1'b1, 17);

        // Early pulse while the checker is untrusted is ignored.
        run_word(40'h0123456789, 2, 1'b1, 17);

        // Back-pressure in DONE with new input offered.
        d4 = 40'hC3A5_9F17E2;
        vc_mode = 1;
        do_accept(d4, 1'b0, 4);
        wait_result(ok);
        held = out_cword;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i >= 2 && i < 8);
            in_data  = 40'hFF00FF00FF;
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_cword", out_cword, held);
            chk("bp_port", enc_y_nr_in_port, d4);
        end
        in_valid = 1'b0;
        handshake();
        @(posedge clk);
        @(negedge clk);
        chk("bp_no_accept", busy, 1'b0);

        // Abort in CHECK.
        vc_mode = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 40'h1111122222;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        chk("clr_busy", busy, 1'b0);
        chk("clr_out_valid", out_valid, 1'b0);
        chk("clr_enc_clr", enc_clr, 1'b1);
        chk("clr_port", enc_y_nr_in_port, '0);
        chk("clr_cnt_ok", cnt_ok, 16'd0);
        chk("clr_cnt_err", cnt_err, 16'd0);
        exp_ok  = '0;
        exp_err = '0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        chk("clr_no_output", ok, 1'b0);
        run_word(40'hABCDEF0123, 1, 1'b0, 4);

        // Saturation of the pass counter.
        @(negedge clk);
        force dut.u_cnt_ok.cnt_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.u_cnt_ok.cnt_q;
        @(negedge clk);
        chk("sat_preload", cnt_ok, 16'hFFFF);
        exp_ok = 16'hFFFF;
        run_word(40'h7777788888, 1, 1'b0, 4);
        chk("sat_hold", cnt_ok, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
